// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : fetch sequencer states
//   INSTR_W       : instruction word width
//   PC_INC        : sequential PC step in bytes
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_INC  = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      KILL = 3'd2,
      HOLD = 3'd3,
      ERR  = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// ---------------------------------------------------------------------------
// fetch_timeout_ctr
// Counts consecutive request cycles that see no ack and flags the cycle in
// which the count would reach MAX_WAIT.
// Ports:
//   clk        in  clock
//   reset      in  asynchronous active-low reset
//   cnt_en_i   in  request outstanding and no ack this cycle
//   clr_i      in  restart the count (ack seen, or no request outstanding)
//   expired_o  out this un-acked cycle is the MAX_WAIT-th in a row
// ---------------------------------------------------------------------------
module fetch_timeout_ctr #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic cnt_en_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_en_i && (cnt_q != CW'(MAX_WAIT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the cycle the count would reach MAX_WAIT; an ack in that
   // same cycle drops cnt_en_i/raises clr_i, so the ack wins.
   assign expired_o = cnt_en_i && !clr_i && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction fetch sequencer for a variable-latency instruction memory with
// a req/ack handshake. Owns the PC, applies branch redirects and holds one
// captured instruction at a time for decode.
// Optional feature: define FETCH_TIMEOUT_EN to add a no-ack watchdog that
// parks the controller in ERR (timeout_F=1) after MAX_WAIT waiting cycles.
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   PCSrc_F        in   redirect request
//   PCBranch_F     in   redirect target (bits [1:0] ignored)
//   stall_F        in   decode not ready, keep holding the instruction
//   imem_req_F     out  fetch request (REQ/KILL)
//   imem_addr_F    out  fetch address, always the current PC
//   imem_ack_F     in   imem data valid this cycle
//   imem_data_F    in   instruction word from imem
//   instr_valid_F  out  instr_F/instr_pc_F valid (HOLD)
//   instr_F        out  captured instruction
//   instr_pc_F     out  PC of instr_F
//   timeout_F      out  sticky fetch timeout (0 unless FETCH_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int             N        = 64,
   parameter logic [N-1:0]   RESET_PC = '0,
   parameter int             MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCSrc_F,
   input  logic [N-1:0]       PCBranch_F,
   input  logic               stall_F,
   output logic               imem_req_F,
   output logic [N-1:0]       imem_addr_F,
   input  logic               imem_ack_F,
   input  logic [INSTR_W-1:0] imem_data_F,
   output logic               instr_valid_F,
   output logic [INSTR_W-1:0] instr_F,
   output logic [N-1:0]       instr_pc_F,
   output logic               timeout_F
);

   fetch_state_t       state_q, state_d;
   logic [N-1:0]       pc_q, pc_d;
   logic [N-1:0]       redir_q, redir_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [N-1:0]       ipc_q, ipc_d;
   logic [N-1:0]       br_tgt;

   // Targets are word aligned; the low two bits are dropped, not trusted.
   assign br_tgt = {PCBranch_F[N-1:2], 2'b00};

   logic unused_br_lsb;
   assign unused_br_lsb = ^PCBranch_F[1:0];

`ifdef FETCH_TIMEOUT_EN
   logic tmo_expired;

   fetch_timeout_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timeout_ctr (
      .clk       (clk),
      .reset     (reset),
      .cnt_en_i  (imem_req_F && !imem_ack_F),
      .clr_i     (!imem_req_F || imem_ack_F),
      .expired_o (tmo_expired)
   );
`else
   // MAX_WAIT only matters when the watchdog is compiled in.
   logic unused_max_wait;
   assign unused_max_wait = (MAX_WAIT > 0);
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      redir_d = redir_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack_F) begin
               if (PCSrc_F) begin
                  // Data belongs to the wrong path; refetch at the target.
                  pc_d = br_tgt;
               end else begin
                  instr_d = imem_data_F;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + N'(PC_INC);
                  state_d = HOLD;
               end
            end else if (PCSrc_F) begin
               // Request cannot be withdrawn: park the target until ack.
               redir_d = br_tgt;
               state_d = KILL;
            end
         end
         KILL: begin
            if (imem_ack_F) begin
               pc_d    = PCSrc_F ? br_tgt : redir_q;
               state_d = REQ;
            end else if (PCSrc_F) begin
               redir_d = br_tgt;
            end
         end
         HOLD: begin
            if (PCSrc_F) begin
               pc_d    = br_tgt;
               state_d = REQ;
            end else if (!stall_F) begin
               state_d = REQ;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
`ifdef FETCH_TIMEOUT_EN
      if (tmo_expired) begin
         state_d = ERR;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         redir_q <= '0;
         instr_q <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   assign imem_req_F    = (state_q == REQ) || (state_q == KILL);
   assign imem_addr_F   = pc_q;
   assign instr_valid_F = (state_q == HOLD);
   assign instr_F       = instr_q;
   assign instr_pc_F    = ipc_q;
`ifdef FETCH_TIMEOUT_EN
   assign timeout_F     = (state_q == ERR);
`else
   assign timeout_F     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Random redirects, stalls and imem latencies against a stream model: decode
// must see RESET_PC, +4, +4 ... restarted at the (word-aligned) target of the
// most recent redirect, each word equal to the memory image at its PC.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

   localparam int          N        = 64;
   localparam logic [63:0] RESET_PC = 64'd0;
   localparam int          MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrc_F;
   logic [63:0] PCBranch_F;
   logic        stall_F;
   logic        imem_req_F;
   logic [63:0] imem_addr_F;
   logic        imem_ack_F;
   logic [31:0] imem_data_F;
   logic        instr_valid_F;
   logic [31:0] instr_F;
   logic [63:0] instr_pc_F;
   logic        timeout_F;

   imem_fetch_ctrl #(
      .N        (N),
      .RESET_PC (RESET_PC),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .PCSrc_F       (PCSrc_F),
      .PCBranch_F    (PCBranch_F),
      .stall_F       (stall_F),
      .imem_req_F    (imem_req_F),
      .imem_addr_F   (imem_addr_F),
      .imem_ack_F    (imem_ack_F),
      .imem_data_F   (imem_data_F),
      .instr_valid_F (instr_valid_F),
      .instr_F       (instr_F),
      .instr_pc_F    (instr_pc_F),
      .timeout_F     (timeout_F)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int presented = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Memory image: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
   endfunction

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];

   task automatic model_start(input logic [63:0] pc);
      exp_t e;
      e.pc    = pc & ~64'h3;
      e.instr = mem_word(e.pc);
      exp_q.delete();
      exp_q.push_back(e);
   endtask

   // ---------------- imem responder ----------------
   logic rsp_new = 1'b1;
   int   rsp_dly = 0;
   int   fixed_delay = -1;
   logic ack_en = 1'b1;

   initial begin
      imem_ack_F  = 1'b0;
      imem_data_F = 32'd0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            imem_ack_F = 1'b0;
            rsp_new    = 1'b1;
         end else if (imem_req_F) begin
            if (rsp_new) begin
               rsp_dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
               rsp_new = 1'b0;
            end
            if (rsp_dly == 0 && ack_en) begin
               imem_ack_F  = 1'b1;
               imem_data_F = mem_word(imem_addr_F);
               rsp_new     = 1'b1;
            end else begin
               imem_ack_F  = 1'b0;
               imem_data_F = $urandom;
               if (rsp_dly > 0) rsp_dly--;
            end
         end else begin
            // Stray acks while no request is outstanding must be ignored.
            imem_ack_F  = ($urandom_range(0, 3) == 0);
            imem_data_F = $urandom;
         end
      end
   end

   // ---------------- monitor ----------------
   logic        mon_en = 1'b0;
   logic        m_pv = 1'b0;
   logic        m_pr = 1'b0;
   logic [63:0] m_pa = 64'd0;
   logic [63:0] m_ppc = 64'd0;
   logic [31:0] m_pin = 32'd0;
   exp_t        m_e;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset || !mon_en) begin
            m_pv = 1'b0;
            m_pr = 1'b0;
         end else begin
            chk("req_with_valid", 64'(imem_req_F & instr_valid_F), 64'd0);
            chk("timeout_low", 64'(timeout_F), 64'd0);
            if (m_pr && imem_req_F && !imem_ack_F)
               chk("addr_stable", imem_addr_F, m_pa);
            if (instr_valid_F && !m_pv) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_instr actual pc=%h required none", instr_pc_F);
               end else begin
                  m_e = exp_q.pop_front();
                  chk("instr_pc", instr_pc_F, m_e.pc);
                  chk("instr", 64'(instr_F), 64'(m_e.instr));
                  presented++;
                  m_e.pc    = m_e.pc + 64'd4;
                  m_e.instr = mem_word(m_e.pc);
                  exp_q.push_back(m_e);
               end
            end else if (instr_valid_F) begin
               chk("hold_pc", instr_pc_F, m_ppc);
               chk("hold_instr", 64'(instr_F), 64'(m_pin));
            end
            m_pv  = instr_valid_F;
            m_pr  = imem_req_F;
            m_pa  = imem_addr_F;
            m_ppc = instr_pc_F;
            m_pin = instr_F;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic check_reset_outputs();
      chk("rst_req", 64'(imem_req_F), 64'd0);
      chk("rst_valid", 64'(instr_valid_F), 64'd0);
      chk("rst_timeout", 64'(timeout_F), 64'd0);
      chk("rst_instr", 64'(instr_F), 64'd0);
      chk("rst_instr_pc", instr_pc_F, 64'd0);
      chk("rst_addr", imem_addr_F, RESET_PC);
   endtask

   task automatic enter_reset();
      @(negedge clk);
      mon_en  = 1'b0;
      PCSrc_F = 1'b0;
      stall_F = 1'b0;
      reset   = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(negedge clk);
   endtask

   // Called at a negedge; the IDLE cycle that follows sees no redirect.
   task automatic release_reset();
      model_start(RESET_PC);
      PCSrc_F = 1'b0;
      reset   = 1'b1;
      mon_en  = 1'b1;
   endtask

   task automatic run_random(input int n);
      logic [63:0] t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         stall_F = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0:       t = 64'hFFFF_FFFF_FFFF_FFFC - 64'(4 * $urandom_range(0, 2));
               1:       t = 64'h0000_0000_0000_0200;
               default: t = 64'($urandom_range(0, 4095));
            endcase
            t          = t | 64'($urandom_range(0, 3));
            PCSrc_F    = 1'b1;
            PCBranch_F = t;
            model_start(t);
         end else begin
            PCSrc_F    = 1'b0;
            PCBranch_F = {$urandom, $urandom};
         end
      end
   endtask

   initial begin
      reset      = 1'b0;
      PCSrc_F    = 1'b0;
      PCBranch_F = 64'd0;
      stall_F    = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs();

      // Zero-wait imem, no stall: valid every second cycle, PCs 0,4,8,...
      @(negedge clk);
      fixed_delay = 0;
      release_reset();
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (k >= 2) chk("valid_pulse", 64'(instr_valid_F), 64'((k % 2) == 0));
      end
      chk("zero_wait_count", 64'(presented), 64'd4);

      @(negedge clk);
      fixed_delay = -1;
      run_random(700);

      // Reset in the middle of traffic aborts everything in flight.
      enter_reset();
      release_reset();
      repeat (2) @(negedge clk);
      run_random(700);
      chk("progress", 64'(presented >= 100), 64'd1);

`ifdef FETCH_TIMEOUT_EN
      // Ack on the MAX_WAIT-th waiting cycle still beats the watchdog.
      enter_reset();
      fixed_delay = MAX_WAIT - 1;
      release_reset();
      stall_F = 1'b0;
      begin
         int before;
         before = presented;
         repeat (70) @(negedge clk);
         chk("late_ack_progress", 64'(presented - before >= 2), 64'd1);
      end
      chk("late_ack_no_timeout", 64'(timeout_F), 64'd0);

      // No ack at all: ERR after MAX_WAIT request cycles.
      enter_reset();
      ack_en = 1'b0;
      model_start(RESET_PC);
      reset = 1'b1;
      for (int k = 1; k <= MAX_WAIT + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == MAX_WAIT) begin
            chk("tmo_req_before", 64'(imem_req_F), 64'd1);
            chk("tmo_flag_before", 64'(timeout_F), 64'd0);
         end
      end
      chk("tmo_flag", 64'(timeout_F), 64'd1);
      chk("tmo_req_dropped", 64'(imem_req_F), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("tmo_sticky", 64'(timeout_F), 64'd1);
      enter_reset();
      ack_en = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
